// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl: 8x8 LED row-scan controller with double-buffered frames
// and tear-free swap at frame boundaries.
module led_matrix_scan_ctrl #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

    logic [7:0]    fb [2][8];
    logic          front_sel;
    logic [2:0]    scan_row;
    logic [CW-1:0] div_cnt;
    logic          frame_end, do_swap, lit;

    assign frame_end   = enable && scan_row == 3'd7 && div_cnt == LAST;
    // with the display dark there is no visible frame to tear, so swap at once
    assign do_swap     = (swap_pending || swap_req) && (!enable || frame_end);
    assign wr_ready    = !swap_pending;
    assign lit         = enable && !reset && div_cnt >= BLANK;
    assign row         = lit ? 8'd1 << scan_row : 8'd0;
    assign col         = lit ? fb[front_sel][scan_row] : 8'd0;
    assign frame_start = enable && !reset && scan_row == 3'd0 && div_cnt == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 8; i++)
                    fb[b][i] <= 8'd0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            scan_row     <= 3'd0;
            div_cnt      <= '0;
        end else begin
            if (wr_valid && wr_ready)
                fb[!front_sel][wr_row] <= wr_data;
            if (!enable) begin
                div_cnt  <= '0;
                scan_row <= 3'd0;
            end else if (div_cnt == LAST) begin
                div_cnt  <= '0;
                scan_row <= scan_row + 3'd1;
            end else begin
                div_cnt  <= div_cnt + 1'b1;
            end
            if (do_swap) begin
                front_sel    <= !front_sel;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// tb_led_matrix_scan_ctrl: directed and randomized checks of the scan controller
// against a frame-position reference model.
module tb_led_matrix_scan_ctrl;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FR = 8 * SD;

    logic       clk = 1'b0;
    logic       reset, enable, wr_valid, swap_req;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       wr_ready, swap_pending, frame_start;
    logic [7:0] row, col;

    led_matrix_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req), .swap_pending(swap_pending), .row(row),
        .col(col), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // model: displayed and written frames, ticks since scanning began, pending flag
    logic [7:0] m_front [8];
    logic [7:0] m_back  [8];
    int         pos;
    bit         pend;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_front[i] = 8'd0;
            m_back[i]  = 8'd0;
        end
        pos  = 0;
        pend = 0;
    endtask

    task automatic m_edge();
        logic [7:0] t;
        bit fe;
        if (reset) begin
            m_reset();
            return;
        end
        if (wr_valid && !pend) m_back[wr_row] = wr_data;
        fe = enable && (pos % FR == FR - 1);
        if ((pend || swap_req) && (!enable || fe)) begin
            for (int i = 0; i < 8; i++) begin
                t = m_front[i];
                m_front[i] = m_back[i];
                m_back[i] = t;
            end
            pend = 0;
        end else if (swap_req) begin
            pend = 1;
        end
        pos = enable ? pos + 1 : 0;
    endtask

    task automatic cyc();
        int r;
        bit on;
        @(negedge clk);
        r  = (pos / SD) % 8;
        on = enable && !reset && (pos % SD) >= BL;
        chk("row", row, on ? 8'(1 << r) : 8'd0);
        chk("col", col, on ? m_front[r] : 8'd0);
        chk("frame_start", {7'd0, frame_start}, {7'd0, enable && !reset && (pos % FR == 0)});
        chk("wr_ready", {7'd0, wr_ready}, {7'd0, !pend});
        chk("swap_pending", {7'd0, swap_pending}, {7'd0, pend});
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        while (pos % FR != target && n < 2 * FR) begin
            cyc();
            n++;
        end
        chk("wait_pos", 8'(pos % FR), 8'(target));
    endtask

    initial begin
        reset = 1; enable = 0; wr_valid = 0; swap_req = 0; wr_row = 0; wr_data = 0;
        m_reset();
        #1;
        repeat (3) cyc();
        reset = 0; enable = 1;
        repeat (130) cyc();
        for (int r = 0; r < 8; r++) begin
            wr_valid = 1; wr_row = 3'(r); wr_data = 8'(1 << r);
            cyc();
        end
        wr_valid = 0;
        swap_req = 1; cyc(); swap_req = 0;
        repeat (130) cyc();
        wait_pos(FR - 1);
        swap_req = 1; cyc(); swap_req = 0;
        repeat (70) cyc();
        for (int r = 0; r < 8; r++) begin
            wr_valid = 1; wr_row = 3'(r); wr_data = 8'hf0 ^ 8'(r);
            cyc();
        end
        wr_valid = 0;
        swap_req = 1; cyc();
        wr_valid = 1; wr_row = 3'd3; wr_data = 8'haa; cyc();
        swap_req = 0; wr_valid = 0;
        repeat (FR + 10) cyc();
        swap_req = 1; cyc(); swap_req = 0;
        repeat (FR + 10) cyc();
        swap_req = 1; cyc(); swap_req = 0;
        enable = 0; repeat (2) cyc();
        enable = 1; repeat (20) cyc();
        wait_pos(4 * SD + 5);
        reset = 1;
        #1;
        chk("reset_row", row, 8'd0);
        chk("reset_col", col, 8'd0);
        m_reset();
        repeat (2) cyc();
        reset = 0;
        repeat (10) cyc();
        enable = 0; swap_req = 1; cyc(); swap_req = 0;
        enable = 1; repeat (FR) cyc();
        repeat (3000) begin
            enable   = $urandom_range(0, 39) != 0;
            wr_valid = $urandom_range(0, 3) == 0;
            wr_row   = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            swap_req = $urandom_range(0, 49) == 0;
            cyc();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
